xy_route_demux: RTL

Per-input-port routing stage of the mesh router. It accepts one AXI-Stream input, decodes the header beat with dimension-ordered XY routing against the router's own coordinates, and steers the whole packet (header plus body beats) to one of CHANNEL_NUMBER outputs. Each output feeds the `in[]` port of the corresponding per-output-direction `arbiter`. The routing decision is locked for the packet's lifetime, so packets never interleave on an output.

---
 rtl/router_pkg.sv | 45 ++++
 rtl/axis_skid_buffer.sv | 52 +++++
 rtl/xy_route_demux.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared mesh-router definitions: port directions, header layout and the
// dimension-ordered XY route function.
package router_pkg;

  localparam int MAX_ROUTERS_X                 = 4;
  localparam int MAX_ROUTERS_Y                 = 4;
  localparam int MAX_ROUTERS_X_WIDTH           = $clog2(MAX_ROUTERS_X);
  localparam int MAX_ROUTERS_Y_WIDTH           = $clog2(MAX_ROUTERS_Y);
  localparam int MAXIMUM_PACKAGES_NUMBER       = 5;
  localparam int MAXIMUM_PACKAGES_NUMBER_WIDTH = $clog2(MAXIMUM_PACKAGES_NUMBER - 1);

  localparam int HDR_X_OFFSET   = 0;
  localparam int HDR_Y_OFFSET   = HDR_X_OFFSET + MAX_ROUTERS_X_WIDTH;
  localparam int HDR_LEN_OFFSET = HDR_Y_OFFSET + MAX_ROUTERS_Y_WIDTH;
  localparam int HEADER_WIDTH   = HDR_LEN_OFFSET + MAXIMUM_PACKAGES_NUMBER_WIDTH;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } dir_e;

  typedef struct packed {
    logic [MAXIMUM_PACKAGES_NUMBER_WIDTH-1:0] len;
    logic [MAX_ROUTERS_Y_WIDTH-1:0]           target_y;
    logic [MAX_ROUTERS_X_WIDTH-1:0]           target_x;
  } header_t;

  // X is resolved fully before Y, which keeps the mesh deadlock-free.
  function automatic dir_e route(
    input logic [MAX_ROUTERS_X_WIDTH-1:0] tx,
    input logic [MAX_ROUTERS_X_WIDTH-1:0] rx,
    input logic [MAX_ROUTERS_Y_WIDTH-1:0] ty,
    input logic [MAX_ROUTERS_Y_WIDTH-1:0] ry
  );
    if (tx > rx)      return EAST;
    else if (tx < rx) return WEST;
    else if (ty > ry) return SOUTH;
    else if (ty < ry) return NORTH;
    else              return LOCAL;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer; s_tready comes straight from a register,
// cutting the ready path while sustaining one beat per cycle.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata
);

  logic [1:0][WIDTH-1:0] mem;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  push;
  logic                  pop;

  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;
  assign s_tready = (count != 2'd2);
  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = mem[rd_ptr];

  // NOTE: payload storage has no reset; only the pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xy_route_demux.sv
// Per-input XY routing demux: decodes the header beat and steers the whole
// packet to one output. Define XY_ROUTE_DEMUX_SKID_EN to register the input.
module xy_route_demux
  import router_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CHANNEL_NUMBER = 5,
  parameter int TID_WIDTH      = 4,
  parameter int TDEST_WIDTH    = 4,
  parameter int TUSER_WIDTH    = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_tvalid,
  output logic                                      in_tready,
  input  logic [DATA_WIDTH-1:0]                     in_tdata,
  input  logic                                      in_tlast,
`ifdef TID_PRESENT
  input  logic [TID_WIDTH-1:0]                      in_tid,
  output logic [CHANNEL_NUMBER-1:0][TID_WIDTH-1:0]  out_tid,
`endif
`ifdef TDEST_PRESENT
  input  logic [TDEST_WIDTH-1:0]                    in_tdest,
  output logic [CHANNEL_NUMBER-1:0][TDEST_WIDTH-1:0] out_tdest,
`endif
`ifdef TUSER_PRESENT
  input  logic [TUSER_WIDTH-1:0]                    in_tuser,
  output logic [CHANNEL_NUMBER-1:0][TUSER_WIDTH-1:0] out_tuser,
`endif
  output logic [CHANNEL_NUMBER-1:0]                 out_tvalid,
  input  logic [CHANNEL_NUMBER-1:0]                 out_tready,
  output logic [CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0] out_tdata,
  output logic [CHANNEL_NUMBER-1:0]                 out_tlast,
  input  logic [MAX_ROUTERS_X_WIDTH-1:0]            router_x,
  input  logic [MAX_ROUTERS_Y_WIDTH-1:0]            router_y,
  output logic                                      busy
);

  localparam int LEN_W = MAXIMUM_PACKAGES_NUMBER_WIDTH;
  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BODY = 1'b1;

  typedef struct packed {
`ifdef TID_PRESENT
    logic [TID_WIDTH-1:0]   tid;
`endif
`ifdef TDEST_PRESENT
    logic [TDEST_WIDTH-1:0] tdest;
`endif
`ifdef TUSER_PRESENT
    logic [TUSER_WIDTH-1:0] tuser;
`endif
    logic                   tlast;
    logic [DATA_WIDTH-1:0]  tdata;
  } beat_t;

  beat_t      in_beat;
  beat_t      s_beat;
  logic       s_valid;
  logic       s_ready;
  logic       state;
  logic [LEN_W-1:0] cnt;
  dir_e       sel_q;
  dir_e       sel;
  header_t    hdr;
  logic       hs;

  assign in_beat.tdata = in_tdata;
  assign in_beat.tlast = in_tlast;
`ifdef TID_PRESENT
  assign in_beat.tid   = in_tid;
`endif
`ifdef TDEST_PRESENT
  assign in_beat.tdest = in_tdest;
`endif
`ifdef TUSER_PRESENT
  assign in_beat.tuser = in_tuser;
`endif

`ifdef XY_ROUTE_DEMUX_SKID_EN
  axis_skid_buffer #(
    .WIDTH($bits(beat_t))
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (in_tvalid),
    .s_tready (in_tready),
    .s_tdata  (in_beat),
    .m_tvalid (s_valid),
    .m_tready (s_ready),
    .m_tdata  (s_beat)
  );
`else
  assign s_valid   = in_tvalid;
  assign s_beat    = in_beat;
  assign in_tready = s_ready;
`endif

  // In IDLE the beat at the steering point is always a header.
  assign hdr = header_t'(s_beat.tdata[HEADER_WIDTH-1:0]);
  assign sel = (state == ST_IDLE) ? route(hdr.target_x, router_x, hdr.target_y, router_y)
                                  : sel_q;
  assign hs  = s_valid && s_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    out_tvalid = '0;
    s_ready    = 1'b0;
    for (int k = 0; k < CHANNEL_NUMBER; k++) begin
      if (sel == dir_e'(3'(k))) begin
        out_tvalid[k] = s_valid;
        s_ready       = out_tready[k];
      end
    end
  end

  assign out_tdata = {CHANNEL_NUMBER{s_beat.tdata}};
  assign out_tlast = {CHANNEL_NUMBER{s_beat.tlast}};
`ifdef TID_PRESENT
  assign out_tid   = {CHANNEL_NUMBER{s_beat.tid}};
`endif
`ifdef TDEST_PRESENT
  assign out_tdest = {CHANNEL_NUMBER{s_beat.tdest}};
`endif
`ifdef TUSER_PRESENT
  assign out_tuser = {CHANNEL_NUMBER{s_beat.tuser}};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sel_q <= LOCAL;
    end else if (hs) begin
      if (state == ST_IDLE) begin
        if (hdr.len != '0) begin
          state <= ST_BODY;
          sel_q <= sel;
          cnt   <= hdr.len;
        end
      end else begin
        cnt <= cnt - CNT_ONE;
        if (cnt == CNT_ONE) state <= ST_IDLE;
      end
    end
  end

  assign busy = (state == ST_BODY);

endmodule
